i2c_slave_rx: RTL and testbench

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_slave_rx_if.sv | 25 ++
 rtl/i2c_slave_rx.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_rx_if
//  Description : I2C bus wires between a bus master (or bench) and the
//                receive-only slave. SDA_down is the slave's open-drain pull.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_rx_if;
  logic SCL;
  logic SDA;
  logic SDA_down;

  modport master (
    output SCL,
    output SDA,
    input  SDA_down
  );

  modport slave (
    input  SCL,
    input  SDA,
    output SDA_down
  );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_rx
//  Description : Write-only I2C slave receiver. Matches a 7-bit address with
//                W, ACKs and stores up to NUM_BYTES data bytes, NACKs beyond.
//                Optional macro I2C_RX_GENCALL_EN also accepts general call
//                (address 7'h00 + W).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_rx #(
  parameter int         NUM_BYTES  = 6,
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic                             FPGA_clk,
  input  logic                             rst_n,
  input  logic                             enable,
  i2c_slave_rx_if.slave                    bus,
  output logic [NUM_BYTES*8-1:0]           rx_data,
  output logic [$clog2(NUM_BYTES+1)-1:0]   rx_count,
  output logic                             done,
  output logic                             busy,
  output logic                             overflow
);

  localparam int                 c_cnt_w = $clog2(NUM_BYTES + 1);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(NUM_BYTES);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
`ifdef I2C_RX_GENCALL_EN
  localparam logic               c_gencall = 1'b1;
`else
  localparam logic               c_gencall = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    DATA      = 3'd3,
    DATA_ACK  = 3'd4,
    WAIT_STOP = 3'd5
  } state_t;

  state_t                 r_state, w_state_n;
  logic                   r_scl_meta, r_scl_sync, r_scl_dly;
  logic                   r_sda_meta, r_sda_sync, r_sda_dly;
  logic [2:0]             r_bit_cnt, w_bit_cnt_n;
  logic [7:0]             r_shift, w_shift_n;
  logic                   r_ack_hi, w_ack_hi_n;
  logic                   r_sda_down, w_sda_down_n;
  logic [NUM_BYTES*8-1:0] w_rx_data_n;
  logic [c_cnt_w-1:0]     w_rx_count_n;
  logic                   w_done_n, w_busy_n, w_overflow_n;

  logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic       w_start, w_stop, w_addr_match;
  logic [7:0] w_byte;

  // Two-flop synchronizers plus one delay flop for edge detection; idle bus is high
  always_ff @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_dly  <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_dly  <= 1'b1;
    end else begin
      r_scl_meta <= bus.SCL;
      r_scl_sync <= r_scl_meta;
      r_scl_dly  <= r_scl_sync;
      r_sda_meta <= bus.SDA;
      r_sda_sync <= r_sda_meta;
      r_sda_dly  <= r_sda_sync;
    end
  end

  assign w_scl_rise = r_scl_sync & ~r_scl_dly;
  assign w_scl_fall = ~r_scl_sync & r_scl_dly;
  assign w_sda_rise = r_sda_sync & ~r_sda_dly;
  assign w_sda_fall = ~r_sda_sync & r_sda_dly;
  assign w_start    = w_sda_fall & r_scl_sync;
  assign w_stop     = w_sda_rise & r_scl_sync;

  // Byte completed by the bit being sampled now; in ADDR, bits [7:1] are the address
  assign w_byte       = {r_shift[6:0], r_sda_sync};
  assign w_addr_match = ~r_sda_sync &
                        ((r_shift[6:0] == SLAVE_ADDR) |
                         (c_gencall & (r_shift[6:0] == 7'h00)));

  // State and datapath registers
  always_ff @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_ack_hi   <= 1'b0;
      r_sda_down <= 1'b0;
      rx_data    <= '0;
      rx_count   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_shift    <= w_shift_n;
      r_ack_hi   <= w_ack_hi_n;
      r_sda_down <= w_sda_down_n;
      rx_data    <= w_rx_data_n;
      rx_count   <= w_rx_count_n;
      done       <= w_done_n;
      busy       <= w_busy_n;
      overflow   <= w_overflow_n;
    end
  end

  // Next state and outputs; enable-low beats START, START beats STOP and SCL edges
  always_comb begin
    w_state_n    = r_state;
    w_bit_cnt_n  = r_bit_cnt;
    w_shift_n    = r_shift;
    w_ack_hi_n   = r_ack_hi;
    w_sda_down_n = r_sda_down;
    w_rx_data_n  = rx_data;
    w_rx_count_n = rx_count;
    w_done_n     = 1'b0;
    w_busy_n     = busy;
    w_overflow_n = overflow;

    if (!enable) begin
      w_state_n    = IDLE;
      w_sda_down_n = 1'b0;
      w_ack_hi_n   = 1'b0;
      w_busy_n     = 1'b0;
    end else if (w_start) begin
      w_state_n    = ADDR;
      w_bit_cnt_n  = 3'd0;
      w_overflow_n = 1'b0;
      w_sda_down_n = 1'b0;
      w_ack_hi_n   = 1'b0;
      w_done_n     = busy;
      w_busy_n     = 1'b0;
    end else if (w_stop) begin
      w_state_n    = IDLE;
      w_sda_down_n = 1'b0;
      w_ack_hi_n   = 1'b0;
      w_done_n     = busy;
      w_busy_n     = 1'b0;
    end else begin
      unique case (r_state)
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_n   = w_byte;
            w_bit_cnt_n = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_addr_match) begin
                w_state_n    = ADDR_ACK;
                w_rx_data_n  = '0;
                w_rx_count_n = '0;
                w_busy_n     = 1'b1;
              end else begin
                w_state_n = WAIT_STOP;
              end
            end
          end
        end
        // The ACK bit spans one SCL low/high/low: pull on the first fall, release on the second
        ADDR_ACK, DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_hi) begin
              w_sda_down_n = 1'b1;
              w_ack_hi_n   = 1'b1;
            end else begin
              w_sda_down_n = 1'b0;
              w_ack_hi_n   = 1'b0;
              w_state_n    = DATA;
            end
          end
        end
        DATA: begin
          if (w_scl_rise) begin
            w_shift_n   = w_byte;
            w_bit_cnt_n = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (rx_count < c_full) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                  if (rx_count == c_cnt_w'(k)) w_rx_data_n[8*k +: 8] = w_byte;
                end
                w_rx_count_n = rx_count + c_one;
                w_state_n    = DATA_ACK;
              end else begin
                w_overflow_n = 1'b1;
                w_state_n    = WAIT_STOP;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.SDA_down = r_sda_down;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_slave_rx
//  Description : Bench for i2c_slave_rx (NUM_BYTES=2). A bit-banged master
//                drives directed transactions; expected done-time contents are
//                queued and checked by a monitor on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_rx;

  localparam int Q = 8;  // clocks per quarter SCL period
`ifdef I2C_RX_GENCALL_EN
  localparam logic GC = 1'b1;
`else
  localparam logic GC = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  count;
    logic        ovf;
  } exp_t;

  logic        FPGA_clk = 1'b0;
  logic        rst_n, enable, sda_m;
  logic [15:0] rx_data;
  logic [1:0]  rx_count;
  logic        done, busy, overflow;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        saw_down, done_prev, a;

  always #5 FPGA_clk = ~FPGA_clk;

  i2c_slave_rx_if bus();
  assign bus.SDA = sda_m & ~bus.SDA_down;

  i2c_slave_rx #(.NUM_BYTES(2), .SLAVE_ADDR(7'h42)) dut (
    .FPGA_clk (FPGA_clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus),
    .rx_data  (rx_data),
    .rx_count (rx_count),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(posedge FPGA_clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q_wait();
    bus.SCL = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    bus.SCL = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q_wait();
    bus.SCL = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; q_wait();
      bus.SCL = 1'b1; q_wait(); q_wait();
      bus.SCL = 1'b0; q_wait();
    end
  endtask

  task automatic ack_bit(output logic ack);
    sda_m = 1'b1; q_wait();
    bus.SCL = 1'b1; q_wait();
    ack = ~bus.SDA; q_wait();
    bus.SCL = 1'b0; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic ack;
    send_bits(b);
    ack_bit(ack);
    check(name, 32'(ack), 32'(exp_ack));
  endtask

  // Every queued done must have arrived within the drain window
  task automatic drain_check(input string name);
    repeat (30) @(posedge FPGA_clk);
    #1;
    check(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; sda_m = 1'b1; bus.SCL = 1'b1;
    saw_down = 1'b0; done_prev = 1'b0;

    fork
      forever begin
        @(negedge FPGA_clk);
        if (bus.SDA_down) saw_down = 1'b1;
        if (done) begin
          check("done_one_cycle", 32'(done_prev), 32'd0);
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: done=1 but no transaction end expected (required done=0)");
          end else begin
            mon_e = q.pop_front();
            check("sb_rx_data",  32'(rx_data),  32'(mon_e.data));
            check("sb_rx_count", 32'(rx_count), 32'(mon_e.count));
            check("sb_overflow", 32'(overflow), 32'(mon_e.ovf));
          end
        end
        done_prev = done;
      end
    join_none

    // Reset state
    repeat (3) @(posedge FPGA_clk);
    #1;
    check("reset_outputs", 32'({bus.SDA_down, done, busy, overflow, rx_count, rx_data}), 32'd0);
    @(negedge FPGA_clk);
    rst_n = 1'b1;
    q_wait();

    // Two bytes to the matching address
    i2c_start();
    write_byte(8'h84, 1'b1, "a_addr_ack");
    check("a_busy", 32'(busy), 32'd1);
    write_byte(8'hA5, 1'b1, "a_d0_ack");
    write_byte(8'h3C, 1'b1, "a_d1_ack");
    q.push_back('{data: 16'h3CA5, count: 2'd2, ovf: 1'b0});
    i2c_stop();
    drain_check("a_done_seen");
    check("a_busy_after", 32'(busy), 32'd0);

    // Wrong address: no ACK anywhere, buffer untouched, no done
    saw_down = 1'b0;
    i2c_start();
    write_byte(8'h86, 1'b0, "b_addr_nack");
    write_byte(8'h11, 1'b0, "b_data_nack");
    i2c_stop();
    drain_check("b_no_done");
    check("b_sda_down_never", 32'(saw_down), 32'd0);
    check("b_rx_hold", 32'({rx_count, rx_data}), 32'({2'd2, 16'h3CA5}));

    // Buffer overflow: third byte NACKed
    i2c_start();
    write_byte(8'h84, 1'b1, "c_addr_ack");
    write_byte(8'h01, 1'b1, "c_d0_ack");
    write_byte(8'h02, 1'b1, "c_d1_ack");
    write_byte(8'h03, 1'b0, "c_d2_nack");
    check("c_overflow", 32'(overflow), 32'd1);
    check("c_rx_data", 32'(rx_data), 32'h0201);
    q.push_back('{data: 16'h0201, count: 2'd2, ovf: 1'b1});
    i2c_stop();
    drain_check("c_done_seen");

    // Repeated START ends the first transaction; START also clears overflow
    i2c_start();
    write_byte(8'h84, 1'b1, "d_addr1_ack");
    write_byte(8'h55, 1'b1, "d_d0_ack");
    q.push_back('{data: 16'h0055, count: 2'd1, ovf: 1'b0});
    i2c_start();
    write_byte(8'h84, 1'b1, "d_addr2_ack");
    write_byte(8'h66, 1'b1, "d_d1_ack");
    q.push_back('{data: 16'h0066, count: 2'd1, ovf: 1'b0});
    i2c_stop();
    drain_check("d_both_done_seen");

    // Enable low aborts: busy and SDA_down drop, STOP produces no done
    i2c_start();
    write_byte(8'h84, 1'b1, "e_addr_ack");
    enable = 1'b0;
    repeat (2) @(posedge FPGA_clk);
    #1;
    check("e_abort_busy_sda", 32'({busy, bus.SDA_down}), 32'd0);
    enable = 1'b1;
    i2c_stop();
    drain_check("e_no_done");

    // General call: accepted only when the feature is built in
    saw_down = 1'b0;
    i2c_start();
    write_byte(8'h00, GC, "g_addr_ack");
    write_byte(8'h7E, GC, "g_data_ack");
    if (GC) q.push_back('{data: 16'h007E, count: 2'd1, ovf: 1'b0});
    i2c_stop();
    drain_check("g_done_as_built");
    check("g_sda_down_seen", 32'(saw_down), 32'(GC));

    // Reset while the address ACK is driven releases SDA at once
    i2c_start();
    send_bits(8'h84);
    check("r_ack_driven", 32'(bus.SDA_down), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("r_async_outputs", 32'({bus.SDA_down, done, busy, overflow, rx_count, rx_data}), 32'd0);
    @(posedge FPGA_clk);
    #2;
    rst_n = 1'b1;
    i2c_stop();
    drain_check("r_no_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
